muldiv_unit: RTL and testbench

Multi-cycle, parametrised M-extension execution unit for the EX stage.
- Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, freeing the single-cycle ALU of wide multipliers and dividers.
- Uses a start/busy/valid handshake so the hazard unit can stall the pipeline on BUSY.
- Uses the same 5-bit SELECT opcode encoding as the EX-stage ALU.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_if.sv | 14 +
 rtl/muldiv_iter_core.sv | 38 +++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcode encoding, FSM state type and opcode classification helpers for the
// iterative M-extension unit.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic is_legal(logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(logic [4:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(logic [4:0] op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // {rs1 signed, rs2 signed}
  function automatic logic [1:0] is_signed(logic [4:0] op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 2'b11;
      OP_MULHSU:               return 2'b10;
      default:                 return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/busy/valid request bus between the EX stage and muldiv_unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic            START;
  logic [4:0]      SELECT;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            KILL;
  logic            BUSY;
  logic            VALID;
  logic [XLEN-1:0] RESULT;

  modport master (output START, SELECT, DATA1, DATA2, KILL, input BUSY, VALID, RESULT);
  modport slave  (input START, SELECT, DATA1, DATA2, KILL, output BUSY, VALID, RESULT);
endinterface

// File: rtl/muldiv_iter_core.sv
// One combinational iteration: UNROLL bits of shift-add multiply or restoring
// shift-subtract divide on the {hi,lo} accumulator.
module muldiv_iter_core #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] opd,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] wide;
  logic [XLEN:0] diff;

  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    wide   = '0;
    diff   = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        // partial remainder stays below 2*divisor, so diff[XLEN] is exactly the borrow
        wide   = {hi_out, lo_out[XLEN-1]};
        diff   = wide - {1'b0, opd};
        lo_out = {lo_out[XLEN-2:0], ~diff[XLEN]};
        hi_out = diff[XLEN] ? wide[XLEN-1:0] : diff[XLEN-1:0];
      end else begin
        wide   = {1'b0, hi_out} + (lo_out[0] ? {1'b0, opd} : '0);
        lo_out = {wide[0], lo_out[XLEN-1:1]};
        hi_out = wide[XLEN:1];
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/DIV/REM execution unit with start/busy/valid handshake and KILL.
// MULDIV_FAST_MUL_EN: multiplies use a single-cycle (XLEN+1)x(XLEN+1) signed multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic     CLK,
  input logic     RESET,
  muldiv_if.slave bus
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [4:0]      op;
  logic [XLEN-1:0] hi, lo, opd, hi_nx, lo_nx, result_q;
  logic            neg_q, neg_r;

  logic            accept, a_neg, b_neg, special;
  logic [1:0]      sgn;
  logic [XLEN-1:0] mag_a, mag_b, special_val, fix_val;

  assign accept = (state == IDLE) && bus.START && !bus.KILL;
  assign sgn    = is_signed(bus.SELECT);
  assign a_neg  = sgn[1] & bus.DATA1[XLEN-1];
  assign b_neg  = sgn[0] & bus.DATA2[XLEN-1];
  assign mag_a  = a_neg ? -bus.DATA1 : bus.DATA1;
  assign mag_b  = b_neg ? -bus.DATA2 : bus.DATA2;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN+1:0] fprod;
  logic                     fast_unused;
  assign fa          = {a_neg, bus.DATA1};
  assign fb          = {b_neg, bus.DATA2};
  assign fprod       = fa * fb;
  assign fast_unused = ^fprod[2*XLEN+1:2*XLEN];
`endif

  // results that need no iteration are registered straight at accept
  always_comb begin
    special     = 1'b1;
    special_val = '0;
    if (!is_legal(bus.SELECT))
      special_val = '0;
    else if (is_div(bus.SELECT) && bus.DATA2 == '0)
      special_val = is_rem(bus.SELECT) ? bus.DATA1 : '1;
    else if (is_div(bus.SELECT) && sgn[0] && bus.DATA1 == MIN_NEG && bus.DATA2 == '1)
      special_val = is_rem(bus.SELECT) ? '0 : bus.DATA1;
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div(bus.SELECT))
      special_val = (bus.SELECT == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif
    else
      special = 1'b0;
  end

  muldiv_iter_core #(.XLEN(XLEN), .UNROLL(UNROLL)) u_core (
    .is_div (is_div(op)),
    .opd    (opd),
    .hi_in  (hi),
    .lo_in  (lo),
    .hi_out (hi_nx),
    .lo_out (lo_nx)
  );

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  always_comb begin
    prod_s  = neg_q ? -{hi, lo} : {hi, lo};
    quo_s   = neg_q ? -lo : lo;
    rem_s   = neg_r ? -hi : hi;
    if (is_div(op))
      fix_val = is_rem(op) ? rem_s : quo_s;
    else
      fix_val = (op == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = special ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.KILL) state_nx = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      result_q <= '0;
      cnt      <= '0;
      op       <= '0;
      hi       <= '0;
      lo       <= '0;
      opd      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (accept) begin
      op    <= bus.SELECT;
      cnt   <= CW'(STEPS);
      hi    <= '0;
      lo    <= is_div(bus.SELECT) ? mag_a : mag_b;
      opd   <= is_div(bus.SELECT) ? mag_b : mag_a;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      if (special) result_q <= special_val;
    end else if (state == CALC) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt - CW'(1);
    end else if (state == FIX && !bus.KILL) begin
      result_q <= fix_val;
    end
  end

  assign bus.BUSY   = (state != IDLE);
  assign bus.VALID  = (state == DONE);
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Random + directed bench for muldiv_unit (UNROLL=1 and UNROLL=4 side by side)
// against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  muldiv_if #(.XLEN(XLEN)) bus ();
  muldiv_if #(.XLEN(XLEN)) bus4 ();

  assign bus4.START  = bus.START;
  assign bus4.SELECT = bus.SELECT;
  assign bus4.DATA1  = bus.DATA1;
  assign bus4.DATA2  = bus.DATA2;
  assign bus4.KILL   = bus.KILL;

  muldiv_unit #(.XLEN(XLEN), .UNROLL(1)) dut  (.CLK(CLK), .RESET(RESET), .bus(bus));
  muldiv_unit #(.XLEN(XLEN), .UNROLL(4)) dut4 (.CLK(CLK), .RESET(RESET), .bus(bus4));

  int checks = 0;
  int errors = 0;
  logic [31:0] last1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0]     p;
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int unroll);
    if (op < OP_MUL || op > OP_REMU) return 1;
    if (op >= OP_DIV) begin
      if (b == 0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    end else if (FAST) return 1;
    return 32 / unroll + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while ((bus.BUSY || bus4.BUSY) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (bus.BUSY || bus4.BUSY) chk("idle_timeout", 1, 0);
  endtask

  // Issue one op on both units, then check result, latency and hold.
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    bit got1 = 0, got4 = 0;
    int l1 = 0, l4 = 0;
    logic [31:0] r1 = 0, r4 = 0, exp;
    wait_idle();
    bus.START = 1'b1; bus.SELECT = op; bus.DATA1 = a; bus.DATA2 = b;
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.SELECT = 5'($urandom); bus.DATA1 = $urandom; bus.DATA2 = $urandom;
    for (int c = 1; c <= 60 && !(got1 && got4); c++) begin
      @(negedge CLK);
      if (c == 1) chk({tag, "/busy"}, bus.BUSY, 1);
      if (bus.VALID && !got1)  begin got1 = 1; l1 = c; r1 = bus.RESULT;  end
      if (bus4.VALID && !got4) begin got4 = 1; l4 = c; r4 = bus4.RESULT; end
    end
    exp = ref_res(op, a, b);
    chk({tag, "/res1"}, r1, exp);
    chk({tag, "/lat1"}, l1, ref_lat(op, a, b, 1));
    chk({tag, "/res4"}, r4, exp);
    chk({tag, "/lat4"}, l4, ref_lat(op, a, b, 4));
    @(negedge CLK);
    chk({tag, "/hold"}, bus.RESULT, exp);
    last1 = exp;
  endtask

  initial begin
    int nv, lat;
    bit got;
    logic [31:0] r;

    bus.START = 0; bus.KILL = 0; bus.SELECT = 0; bus.DATA1 = 0; bus.DATA2 = 0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_busy",   bus.BUSY,    0);
    chk("rst_valid",  bus.VALID,   0);
    chk("rst_result", bus.RESULT,  0);
    chk("rst_busy4",  bus4.BUSY,   0);
    chk("rst_res4",   bus4.RESULT, 0);
    last1 = 0;

    run(OP_DIV,    32'hFFFF_FFF9, 32'h2,          "div_neg");
    run(OP_REM,    32'hFFFF_FFF9, 32'h2,          "rem_neg");
    run(OP_DIVU,   32'h5,         32'h0,          "divu_zero");
    run(OP_REMU,   32'h5,         32'h0,          "remu_zero");
    run(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF,  "div_ovf");
    run(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF,  "rem_ovf");
    run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  "mulhu_m1");
    run(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF,  "mulh_m1");
    run(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  "mulhsu_m1");
    run(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF,  "mul_m1");
    run(OP_MULH,   32'h8000_0000, 32'h8000_0000,  "mulh_min");
    run(OP_DIVU,   32'd100,       32'd7,          "divu_100_7");
    run(5'b00000,  32'h1234,      32'h5678,       "illegal_lo");
    run(5'b11111,  32'h1234,      32'h5678,       "illegal_hi");

    // KILL at N+10 of a DIV, new START at N+11
    wait_idle();
    bus.START = 1; bus.SELECT = OP_DIV; bus.DATA1 = 32'd100; bus.DATA2 = 32'd3;
    @(posedge CLK); #1 bus.START = 0;
    nv = 0; got = 0; lat = 0; r = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge CLK);
      if (bus.VALID) begin
        if (c <= 40) nv++;
        else if (!got) begin got = 1; lat = c; r = bus.RESULT; end
      end
      if (c == 10) bus.KILL = 1;
      if (c == 11) begin
        bus.KILL = 0;
        chk("kill_busy", bus.BUSY, 0);
        chk("kill_keep", bus.RESULT, last1);
        bus.START = 1; bus.SELECT = OP_DIVU; bus.DATA1 = 32'd1000; bus.DATA2 = 32'd7;
      end
      if (c == 12) bus.START = 0;
    end
    chk("kill_novalid", nv, 0);
    chk("kill_relat", lat, 45);
    chk("kill_reres", r, 142);
    last1 = 142;

    // START pulse while busy is ignored
    wait_idle();
    bus.START = 1; bus.SELECT = OP_DIV; bus.DATA1 = 32'hFFFF_FF00; bus.DATA2 = 32'h10;
    @(posedge CLK); #1 bus.START = 0;
    nv = 0; lat = 0; r = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (bus.VALID) begin nv++; lat = c; r = bus.RESULT; end
      if (c == 5) begin bus.START = 1; bus.SELECT = OP_REMU; bus.DATA1 = 77; bus.DATA2 = 5; end
      if (c == 6) bus.START = 0;
    end
    chk("ign_count", nv, 1);
    chk("ign_lat", lat, 34);
    chk("ign_res", r, 32'hFFFF_FFF0);

    // RESET mid-operation
    wait_idle();
    bus.START = 1; bus.SELECT = OP_MULHU; bus.DATA1 = $urandom; bus.DATA2 = $urandom;
    @(posedge CLK); #1 bus.START = 0;
    nv = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (bus.VALID) nv++;
      if (c == 8) RESET = 1;
      if (c == 9) begin
        RESET = 0;
        chk("mrst_busy", bus.BUSY, 0);
        chk("mrst_res", bus.RESULT, 0);
      end
    end
    chk("mrst_novalid", nv, 0);

    for (int i = 0; i < 150; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(11, 18));
      run(op, pick(), pick(), $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
